fp_class_arb: RTL and testbench
===============================

# fp_class_arb

Shared-classifier arbiter that lets NREQ independent requesters time-share one combinational floating-point classifier. Each requester presents an IEEE 754 binary operand with valid/ready. The block grants one requester per cycle round-robin, classifies the operand in a two-stage pipeline, and returns the unpacked exponent/significand, a one-hot class and the requester ID on a single valid/ready response port. It sits between the FPU operand front-ends and the arithmetic units that consume unpacked operands.

## Interface
- NEXP, 5, exponent field width
- NSIG, 10, stored fraction width
- NREQ, 4, number of requesters (≥2)
- IDW, $clog2(NREQ), requester ID width

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester operand valid
- req_f  in  NREQ*(NEXP+NSIG+1)  packed operands; requester i at bits [i*W +: W], W=NEXP+NSIG+1
- req_ready  out  NREQ  per-requester accept; at most one bit high
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  index of the requester that issued this response
- rsp_sign  out  1  operand sign bit
- rsp_exp  out  NEXP+2 signed  unbiased exponent (normal/subnormal); raw zero-extended field otherwise
- rsp_sig  out  NSIG+1  significand with implied/normalised leading 1; raw fraction (MSB 0) otherwise
- rsp_class  out  6  one-hot {snan, qnan, inf, zero, subnormal, normal}

## Operation
- Arbitration: combinational round-robin over req_valid, starting at pointer `ptr`. The winner g gets req_ready[g]=1 iff stage A can accept.
- Accept = req_valid[g] & req_ready[g]. On accept, ptr <= (g+1) mod NREQ. ptr holds when there is no accept.
- req_ready depends on req_valid; requesters must hold req_valid and their operand stable until accepted and must not gate valid on ready.
- Stage A register: {f, id, valid_a}. The classifier operates on stage A combinationally.
- Stage B register: classifier outputs + sign + id, and valid_b = rsp_valid.
- Advance rules: B loads when !valid_b | rsp_ready. A can accept when !valid_a | B loads. When A is emptied without a new accept, valid_a <= 0.
- Classification (width rules):
  - normal: exp = field − BIAS, where BIAS = 2^(NEXP−1)−1; sig = {1, fraction}.
  - subnormal: sig shifted left until the MSB is set; exp = (1−BIAS) − shift.
  - snan/qnan/inf/zero: exp = {00, field}; sig = {0, fraction}.
- Exactly one rsp_class bit is set whenever rsp_valid=1.
- Responses are returned in accept order. There is no reordering and no loss under backpressure.

## Timing
- Latency: operand accepted at edge T → response visible in the cycle after edge T+1, provided rsp_ready was high. Throughput is 1 operand per cycle.
- Full condition: valid_a & valid_b & !rsp_ready → all req_ready=0.
- rsp_* data holds stable while rsp_valid & !rsp_ready.
- Reset (any cycle, including mid-stream):
  - ptr=0, valid_a=0, rsp_valid=0.
  - rsp_id, rsp_sign, rsp_exp, rsp_sig, rsp_class = 0.
  - In-flight operands are discarded.
  - In the reset cycle itself req_ready=0; from the next cycle arbitration starts at requester 0.
- Simultaneous accept and response handshake in the same cycle is legal and keeps the pipe full.

## Structure
- Package `fp_pkg`:
  - class bit index constants CLS_SNAN=5, CLS_QNAN=4, CLS_INF=3, CLS_ZERO=2, CLS_SUB=1, CLS_NORM=0
  - function bias(NEXP)
  - typedef for the 6-bit class vector
- Sub-modules:
  - the team's existing `fp_class` classifier, instantiated once on stage A
  - `rr_arb` (NREQ-wide round-robin grant, pointer input, one-hot grant plus encoded index)
- Top level holds the pipeline registers and handshake logic.

## Test plan
- Reset: hold rst 2 cycles with all req_valid=1 → req_ready=0 and rsp_valid=0 during reset; the first grant after reset is requester 0.
- Single normal operand: requester 2 sends 16'h3C00 → 2 cycles later rsp_id=2, rsp_exp=0, rsp_sig=11'h400, rsp_class=6'b000001, rsp_sign=0.
- Subnormal operand: 16'h0001 → rsp_exp=−24, rsp_sig=11'h400, class subnormal. Also 16'h0200 → rsp_exp=−15, rsp_sig=11'h400.
- Special values:
  - 16'h7E00 → qnan, exp=31, sig=11'h200
  - 16'h7C01 → snan
  - 16'h7C00 → inf, sig=0
  - 16'h8000 → zero with rsp_sign=1, exp=0
- Fairness: all 4 requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,1…, one response per cycle, IDs in the same order.
- Backpressure/reset mid-op:
  - Streaming, drop rsp_ready for 3 cycles → both stages fill, all req_ready=0, rsp data stable, no loss or duplication after release.
  - Assert rst with both stages full → rsp_valid=0 next cycle, and the discarded operands never appear.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point classifier arbiter: class bit
// positions, the one-hot class vector type and the exponent bias helper.
package fp_pkg;

    localparam int CLS_SNAN = 5;
    localparam int CLS_QNAN = 4;
    localparam int CLS_INF  = 3;
    localparam int CLS_ZERO = 2;
    localparam int CLS_SUB  = 1;
    localparam int CLS_NORM = 0;
    localparam int NCLS     = 6;

    typedef logic [NCLS-1:0] class_t;

    function automatic int bias(input int nexp);
        return (1 << (nexp - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_class_arb_if.sv
// Requester and response bundle of the classifier arbiter.
// The master drives operands and response ready; the slave (arbiter) drives grants and responses.
interface fp_class_arb_if import fp_pkg::*; #(
    parameter int NEXP = 5,
    parameter int NSIG = 10,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    localparam int W = NEXP + NSIG + 1;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*W-1:0]      req_f;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic                   rsp_sign;
    logic signed [NEXP+1:0] rsp_exp;
    logic [NSIG:0]          rsp_sig;
    class_t                 rsp_class;

    modport master (
        output req_valid, req_f, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sign, rsp_exp, rsp_sig, rsp_class
    );

    modport slave (
        input  req_valid, req_f, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sign, rsp_exp, rsp_sig, rsp_class
    );

endinterface

// File: rtl/fp_class.sv
// Combinational IEEE 754 classifier/unpacker; zero latency, no handshake.
// Subnormals are normalised so the significand MSB is always set for finite non-zero values.
module fp_class import fp_pkg::*; #(
    parameter int NEXP = 5,
    parameter int NSIG = 10
) (
    input  logic [NEXP+NSIG:0]     f,
    output logic                   sign,
    output logic signed [NEXP+1:0] expOut,
    output logic [NSIG:0]          sig,
    output class_t                 cls
);
    localparam int EW = NEXP + 2;
    localparam int SW = $clog2(NSIG + 1);
    localparam logic [EW-1:0] BIASV = EW'(bias(NEXP));

    logic [NEXP-1:0] field;
    logic [NSIG-1:0] frac;
    logic [SW-1:0]   lead;
    logic [SW-1:0]   shamt;

    assign sign  = f[NEXP+NSIG];
    assign field = f[NEXP+NSIG-1:NSIG];
    assign frac  = f[NSIG-1:0];

    // Position of the highest set fraction bit; the last hit in the loop wins.
    always_comb begin
        lead = '0;
        for (int i = 0; i < NSIG; i++) begin
            if (frac[i]) lead = SW'(i);
        end
    end

    assign shamt = SW'(NSIG) - lead;

    always_comb begin
        cls    = '0;
        expOut = $signed(EW'(field));
        sig    = {1'b0, frac};
        if (field == '1) begin
            if (frac == '0)          cls[CLS_INF]  = 1'b1;
            else if (frac[NSIG-1])   cls[CLS_QNAN] = 1'b1;
            else                     cls[CLS_SNAN] = 1'b1;
        end else if (field == '0) begin
            if (frac == '0) begin
                cls[CLS_ZERO] = 1'b1;
            end else begin
                cls[CLS_SUB] = 1'b1;
                sig    = {1'b0, frac} << shamt;
                expOut = $signed(EW'(1) - BIASV - EW'(shamt));
            end
        end else begin
            cls[CLS_NORM] = 1'b1;
            sig    = {1'b1, frac};
            expOut = $signed(EW'(field) - BIASV);
        end
    end

endmodule

// File: rtl/fp_class_arb_rr_arb.sv
// Round-robin grant starting at ptr; combinational, zero latency.
// Grants only requesters with valid high; ready gating is left to the caller.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(ptr) + i) % NREQ;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/fp_class_arb.sv
// Round-robin front end sharing one classifier; accept to response valid is 2 cycles, 1/cycle throughput.
// Stage A stalls only when stage B holds an unconsumed response; grants drop to zero when both are full.
module fp_class_arb import fp_pkg::*; #(
    parameter int NEXP = 5,
    parameter int NSIG = 10,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic          clk,
    input  logic          rst,
    fp_class_arb_if.slave bus
);
    localparam int W = NEXP + NSIG + 1;

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gIdx;
    logic [NREQ-1:0] gnt;
    logic            anyReq;

    logic            validA;
    logic [W-1:0]    fA;
    logic [IDW-1:0]  idA;

    logic                   validB;
    logic [IDW-1:0]         idB;
    logic                   signB;
    logic signed [NEXP+1:0] expB;
    logic [NSIG:0]          sigB;
    class_t                 clsB;

    logic                   cSign;
    logic signed [NEXP+1:0] cExp;
    logic [NSIG:0]          cSig;
    class_t                 cCls;

    logic loadB;
    logic canAccept;
    logic accept;

    rr_arb #(.NREQ(NREQ), .IDW(IDW)) uArb (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gIdx),
        .any (anyReq)
    );

    fp_class #(.NEXP(NEXP), .NSIG(NSIG)) uClass (
        .f      (fA),
        .sign   (cSign),
        .expOut (cExp),
        .sig    (cSig),
        .cls    (cCls)
    );

    assign loadB         = !validB || bus.rsp_ready;
    // Reset masks grants combinationally so nothing is offered in the reset cycle.
    assign canAccept     = !rst && (!validA || loadB);
    assign bus.req_ready = canAccept ? gnt : '0;
    assign accept        = canAccept && anyReq;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            validA <= 1'b0;
            fA     <= '0;
            idA    <= '0;
            validB <= 1'b0;
            idB    <= '0;
            signB  <= 1'b0;
            expB   <= '0;
            sigB   <= '0;
            clsB   <= '0;
        end else begin
            if (accept) begin
                ptr    <= (int'(gIdx) == NREQ - 1) ? '0 : gIdx + IDW'(1);
                fA     <= bus.req_f[int'(gIdx)*W +: W];
                idA    <= gIdx;
                validA <= 1'b1;
            end else if (loadB) begin
                validA <= 1'b0;
            end

            if (loadB) begin
                validB <= validA;
                if (validA) begin
                    idB   <= idA;
                    signB <= cSign;
                    expB  <= cExp;
                    sigB  <= cSig;
                    clsB  <= cCls;
                end
            end
        end
    end

    assign bus.rsp_valid = validB;
    assign bus.rsp_id    = idB;
    assign bus.rsp_sign  = signB;
    assign bus.rsp_exp   = expB;
    assign bus.rsp_sig   = sigB;
    assign bus.rsp_class = clsB;

endmodule

// File: tb/tb_fp_class_arb.sv
// Directed bench for fp_class_arb: reset, classification corners, fairness,
// backpressure and mid-stream reset, with hand-computed expectations.
module tb_fp_class_arb;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp_class_arb_if #(.NEXP(5), .NSIG(10), .NREQ(4)) bus ();

    fp_class_arb #(.NEXP(5), .NSIG(10), .NREQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Backpressure scenario: per-cycle expected grant, response valid and id.
    logic [3:0] bpReady [0:10] = '{4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0};
    logic       bpVld   [0:10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] bpId    [0:10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst           = 1'b1;
        bus.req_valid = 4'hF;
        tick();
        chk("rst_ready_c1", bus.req_ready, 0);
        chk("rst_vld_c1", bus.rsp_valid, 0);
        tick();
        chk("rst_ready_c2", bus.req_ready, 0);
        chk("rst_vld_c2", bus.rsp_valid, 0);
        chk("rst_class", bus.rsp_class, 0);
        chk("rst_id", bus.rsp_id, 0);
        rst           = 1'b0;
        bus.req_valid = 4'h0;
    endtask

    task automatic classify(input int id, input logic [15:0] val, input logic [6:0] eExp,
                            input logic [10:0] eSig, input logic [5:0] eCls, input logic eSign);
        bus.req_f              = '0;
        bus.req_f[id*16 +: 16] = val;
        bus.req_valid          = 4'b1 << id;
        #1;
        chk("cls_ready", bus.req_ready, 32'(4'b1 << id));
        tick();
        bus.req_valid = 4'h0;
        chk("cls_vld_early", bus.rsp_valid, 0);
        tick();
        chk("cls_vld", bus.rsp_valid, 1);
        chk("cls_id", bus.rsp_id, id);
        chk("cls_sign", bus.rsp_sign, eSign);
        chk("cls_exp", $unsigned(bus.rsp_exp), eExp);
        chk("cls_sig", bus.rsp_sig, eSig);
        chk("cls_class", bus.rsp_class, eCls);
        tick();
        chk("cls_vld_after", bus.rsp_valid, 0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 4'h0;
        bus.req_f     = {4{16'h3C00}};
        bus.rsp_ready = 1'b1;

        doReset();
        bus.req_valid = 4'hF;
        #1;
        chk("first_grant", bus.req_ready, 4'h1);
        bus.req_valid = 4'h0;
        tick();
        chk("idle_vld", bus.rsp_valid, 0);

        // Classification corners: exp is 7-bit two's complement.
        classify(2, 16'h3C00, 7'h00, 11'h400, 6'b000001, 1'b0);
        classify(1, 16'h0001, 7'h68, 11'h400, 6'b000010, 1'b0);
        classify(3, 16'h0200, 7'h71, 11'h400, 6'b000010, 1'b0);
        classify(0, 16'h03FF, 7'h71, 11'h7FE, 6'b000010, 1'b0);
        classify(1, 16'h0400, 7'h72, 11'h400, 6'b000001, 1'b0);
        classify(2, 16'h7BFF, 7'h0F, 11'h7FF, 6'b000001, 1'b0);
        classify(3, 16'hC500, 7'h02, 11'h500, 6'b000001, 1'b1);
        classify(0, 16'h7E00, 7'h1F, 11'h200, 6'b010000, 1'b0);
        classify(1, 16'h7C01, 7'h1F, 11'h001, 6'b100000, 1'b0);
        classify(2, 16'h7C00, 7'h1F, 11'h000, 6'b001000, 1'b0);
        classify(3, 16'h8000, 7'h00, 11'h000, 6'b000100, 1'b1);

        // Fairness: all requesters valid, consumer always ready.
        doReset();
        bus.req_f     = {16'h3C03, 16'h3C02, 16'h3C01, 16'h3C00};
        bus.rsp_ready = 1'b1;
        for (int cyc = 0; cyc <= 10; cyc++) begin
            bus.req_valid = (cyc < 8) ? 4'hF : 4'h0;
            #1;
            chk("rr_ready", bus.req_ready, (cyc < 8) ? (32'd1 << (cyc % 4)) : 32'd0);
            chk("rr_vld", bus.rsp_valid, (cyc >= 2 && cyc < 10) ? 1 : 0);
            if (cyc >= 2 && cyc < 10) begin
                chk("rr_id", bus.rsp_id, (cyc - 2) % 4);
                chk("rr_sig", bus.rsp_sig, 32'h400 + 32'((cyc - 2) % 4));
            end
            tick();
        end

        // Backpressure: consumer stalls for cycles 2..4 while requesters stream.
        doReset();
        for (int cyc = 0; cyc <= 10; cyc++) begin
            bus.req_valid = (cyc < 8) ? 4'hF : 4'h0;
            bus.rsp_ready = (cyc >= 2 && cyc <= 4) ? 1'b0 : 1'b1;
            #1;
            chk("bp_ready", bus.req_ready, bpReady[cyc]);
            chk("bp_vld", bus.rsp_valid, bpVld[cyc]);
            if (bpVld[cyc]) begin
                chk("bp_id", bus.rsp_id, bpId[cyc]);
                chk("bp_sig", bus.rsp_sig, 32'h400 | 32'(bpId[cyc]));
                chk("bp_class", bus.rsp_class, 6'b000001);
            end
            tick();
        end

        // Reset with both stages full: in-flight operands must vanish.
        doReset();
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b1;
        #1;
        tick();
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        chk("full_ready", bus.req_ready, 0);
        chk("full_vld", bus.rsp_valid, 1);
        chk("full_id", bus.rsp_id, 0);
        rst = 1'b1;
        tick();
        chk("midrst_vld", bus.rsp_valid, 0);
        chk("midrst_sig", bus.rsp_sig, 0);
        chk("midrst_class", bus.rsp_class, 0);
        rst           = 1'b0;
        bus.req_valid = 4'h0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("midrst_drain", bus.rsp_valid, 0);
        end
        classify(3, 16'h3C03, 7'h00, 11'h403, 6'b000001, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
